// File: rtl/fc_stream_pkg.sv
// Fixed-point formats shared by the fully-connected layer datapath blocks.
package fc_stream_pkg;

  localparam int unsigned FRAC_W = 7;
  localparam int unsigned ACT_W  = 8;
  localparam int unsigned DAT_W  = 16;

  // [1,7] activation to [9,7] data: equal fraction widths, so only the sign is extended.
  function automatic logic [DAT_W-1:0] sign_ext(input logic [ACT_W-1:0] e);
    return {{(DAT_W-ACT_W){e[ACT_W-1]}}, e};
  endfunction

endpackage

// File: rtl/fc_vec_serializer.sv
// Parallel-to-serial converter between FC layers, with a two-vector ping-pong buffer
// and a sticky overflow flag in place of backpressure.
module fc_vec_serializer
  import fc_stream_pkg::*;
#(
  parameter int unsigned DIM   = 8,
  parameter int unsigned IN_W  = ACT_W,
  parameter int unsigned OUT_W = DAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_dat [DIM-1:0],
  input  logic             in_valid,
  output logic [OUT_W-1:0] out_dat,
  output logic             out_valid,
  output logic             out_last,
  output logic             overflow
);

  localparam int unsigned IdxW = (DIM > 1) ? $clog2(DIM) : 1;

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [OUT_W-1:0] out_dat_q, out_dat_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             overflow_q, overflow_d;
  logic [IN_W-1:0]  buf_q [2][DIM];
  logic [IN_W-1:0]  buf_d [2][DIM];

  logic rel;
  logic accept;

  function automatic logic [OUT_W-1:0] ext(input logic [IN_W-1:0] e);
    return OUT_W'($signed(e));
  endfunction

  always_comb begin
    state_d     = state_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    idx_d       = idx_q;
    out_dat_d   = out_dat_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    overflow_d  = overflow_q;
    buf_d       = buf_q;

    // The streamed buffer frees up at the edge ending its out_last cycle, so a full
    // buffer pair can still take a vector in that cycle.
    rel    = (state_q == StStream) && out_last_q;
    accept = in_valid && ((cnt_q != 2'd2) || rel);

    if (in_valid && !accept) begin
      overflow_d = 1'b1;
    end

    if (accept) begin
      for (int i = 0; i < DIM; i++) begin
        buf_d[wr_sel_q][i] = in_dat[i];
      end
      wr_sel_d = ~wr_sel_q;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d     = StStream;
          idx_d       = '0;
          out_dat_d   = ext(in_dat[0]);
          out_valid_d = 1'b1;
        end
      end
      StStream: begin
        if (rel) begin
          rd_sel_d = ~rd_sel_q;
          idx_d    = '0;
          if (cnt_q == 2'd2) begin
            out_dat_d   = ext(buf_q[~rd_sel_q][0]);
            out_valid_d = 1'b1;
          end else if (accept) begin
            // Vector landing in the other buffer on the release cycle: no bubble.
            out_dat_d   = ext(in_dat[0]);
            out_valid_d = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          idx_d       = idx_q + 1'b1;
          out_dat_d   = ext(buf_q[rd_sel_q][idx_d]);
          out_valid_d = 1'b1;
          out_last_d  = (idx_d == IdxW'(DIM - 1));
        end
      end
      default: state_d = StIdle;
    endcase

    cnt_d = cnt_q + {1'b0, accept} - {1'b0, rel};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 2'd0;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      idx_q       <= '0;
      out_dat_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      idx_q       <= idx_d;
      out_dat_q   <= out_dat_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      overflow_q  <= overflow_d;
    end
  end

  // Vector storage needs no reset; contents are only read while occupied.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign out_dat   = out_dat_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fc_vec_serializer.sv
// Directed and random-spacing bench for fc_vec_serializer with per-cycle expectation tables.
module tb_fc_vec_serializer;

  localparam int NC = 64;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_dat [7:0];
  logic        in_valid;
  logic [15:0] out_dat;
  logic        out_valid;
  logic        out_last;
  logic        overflow;

  fc_vec_serializer #(
    .DIM   (8),
    .IN_W  (8),
    .OUT_W (16)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_dat    (in_dat),
    .in_valid  (in_valid),
    .out_dat   (out_dat),
    .out_valid (out_valid),
    .out_last  (out_last),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Vector ids: 0=A 1=B 2=C 3=D, 4..7 random.
  logic [7:0]  vec_tab [8][8];
  logic [15:0] exp_tab [8][8];

  int inj_at [4];
  int inj_id [4];
  int n_inj;
  int rst_at;

  logic        ev [NC];
  logic        el [NC];
  logic        eo [NC];
  logic        ez [NC];
  logic [15:0] ed [NC];

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [15:0] sext(input logic [7:0] e);
    return {{8{e[7]}}, e};
  endfunction

  task automatic clear_exp();
    for (int c = 0; c < NC; c++) begin
      ev[c] = 1'b0; el[c] = 1'b0; eo[c] = 1'b0; ez[c] = 1'b0; ed[c] = '0;
    end
    n_inj  = 0;
    rst_at = -1;
  endtask

  task automatic inject(input int at, input int id);
    inj_at[n_inj] = at;
    inj_id[n_inj] = id;
    n_inj++;
  endtask

  task automatic add_stream(input int start, input int id, input int n);
    for (int i = 0; i < n; i++) begin
      ev[start+i] = 1'b1;
      ed[start+i] = exp_tab[id][i];
      el[start+i] = (i == 7);
    end
  endtask

  task automatic set_ovf(input int from);
    for (int c = from; c < NC; c++) eo[c] = 1'b1;
  endtask

  task automatic do_reset(input logic chk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (chk) begin
      check_eq("reset out_dat", out_dat, 16'h0000);
      check_eq("reset out_valid", 16'(out_valid), 16'd0);
      check_eq("reset out_last", 16'(out_last), 16'd0);
      check_eq("reset overflow", 16'(overflow), 16'd0);
    end
    rst_n = 1'b1;
  endtask

  task automatic run(input string name, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      in_valid = 1'b0;
      rst_n    = (c != rst_at);
      for (int k = 0; k < n_inj; k++) begin
        if (inj_at[k] == c) begin
          in_valid = 1'b1;
          for (int i = 0; i < 8; i++) in_dat[i] = vec_tab[inj_id[k]][i];
        end
      end
      check_eq($sformatf("%s c%0d out_valid", name, c), 16'(out_valid), 16'(ev[c]));
      check_eq($sformatf("%s c%0d out_last", name, c), 16'(out_last), 16'(el[c]));
      check_eq($sformatf("%s c%0d overflow", name, c), 16'(overflow), 16'(eo[c]));
      if (ev[c]) check_eq($sformatf("%s c%0d out_dat", name, c), out_dat, ed[c]);
      if (ez[c]) check_eq($sformatf("%s c%0d out_dat zero", name, c), out_dat, 16'h0000);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  initial begin
    int t;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) in_dat[i] = '0;

    vec_tab[0] = '{8'h7F, 8'h80, 8'h01, 8'hFF, 8'h00, 8'h40, 8'hC0, 8'h7E};
    vec_tab[1] = '{8'h11, 8'h92, 8'h23, 8'hA4, 8'h35, 8'hB6, 8'h47, 8'hC8};
    vec_tab[2] = '{8'hF0, 8'h0F, 8'hE1, 8'h1E, 8'hD2, 8'h2D, 8'hC3, 8'h3C};
    vec_tab[3] = '{8'h05, 8'hFA, 8'h06, 8'hF9, 8'h07, 8'hF8, 8'h08, 8'hF7};
    for (int v = 4; v < 8; v++)
      for (int i = 0; i < 8; i++) vec_tab[v][i] = 8'($urandom);
    // Vector A expectations written out by hand.
    exp_tab[0] = '{16'h007F, 16'hFF80, 16'h0001, 16'hFFFF,
                   16'h0000, 16'h0040, 16'hFFC0, 16'h007E};
    for (int v = 1; v < 8; v++)
      for (int i = 0; i < 8; i++) exp_tab[v][i] = sext(vec_tab[v][i]);

    do_reset(1'b1);
    clear_exp();
    inject(0, 0);
    add_stream(1, 0, 8);
    run("single", 12);

    do_reset(1'b0);
    clear_exp();
    inject(0, 0);
    inject(3, 1);
    add_stream(1, 0, 8);
    add_stream(9, 1, 8);
    run("b2b", 20);

    do_reset(1'b0);
    clear_exp();
    inject(0, 0);
    inject(1, 1);
    inject(2, 2);
    add_stream(1, 0, 8);
    add_stream(9, 1, 8);
    set_ovf(3);
    run("ovf", 20);

    do_reset(1'b0);
    clear_exp();
    inject(0, 0);
    inject(1, 1);
    inject(8, 2);
    add_stream(1, 0, 8);
    add_stream(9, 1, 8);
    add_stream(17, 2, 8);
    run("simul", 28);

    do_reset(1'b0);
    clear_exp();
    inject(0, 0);
    inject(2, 1);
    inject(7, 3);
    rst_at = 4;
    add_stream(1, 0, 4);
    ez[5] = 1'b1;
    ez[6] = 1'b1;
    ez[7] = 1'b1;
    add_stream(8, 3, 8);
    run("rstmid", 20);

    do_reset(1'b0);
    clear_exp();
    t = 0;
    for (int v = 4; v < 8; v++) begin
      inject(t, v);
      add_stream(t + 1, v, 8);
      t += 8 + int'($urandom_range(0, 4));
    end
    run("rand", t + 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
